// File: rtl/mips_pkg.sv
// Shared types, defaults and helpers for the unified-memory arbiter.
package mips_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned MAX_D_RUN_DEF = 4;
    localparam int unsigned TIMEOUT_DEF   = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_t;

    // Latched memory command, held stable on the memory bus for a whole access.
    typedef struct packed {
        logic              wr;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 32'd1) ? 32'd1 : 32'($clog2(max_val + 32'd1));
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-port memory,
// with a bounded data run while a fetch waits and a per-access timeout.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned MAX_D_RUN = MAX_D_RUN_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam int unsigned      RUN_W    = cnt_width(MAX_D_RUN);
    localparam int unsigned      TMO_W    = cnt_width(TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_D_RUN);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 32'd1);

    arb_state_t         r_state, w_state;
    logic [RUN_W-1:0]   r_run, w_run;
    logic [TMO_W-1:0]   r_tmo, w_tmo;
    mem_cmd_t           r_cmd, w_cmd;
    logic               r_mem_req, w_mem_req;
    logic [31:0]        r_if_rdata, w_if_rdata;
    logic [31:0]        r_d_rdata, w_d_rdata;
    logic               r_if_ready, w_if_ready;
    logic               r_d_ready, w_d_ready;
    logic               r_err, w_err;

    logic               w_grant_d;
    logic               w_timeout;
    logic [31:0]        w_read_data;

    // Data wins a tie unless it has already taken MAX_D_RUN grants past a waiting fetch.
    assign w_grant_d   = d_req && !(if_req && (r_run == RUN_MAX));
    assign w_timeout   = !mem_ack && (r_tmo == TMO_LAST);
    assign w_read_data = r_cmd.wr ? 32'd0 : mem_rdata;

    always_comb begin
        w_state    = r_state;
        w_run      = r_run;
        w_tmo      = r_tmo;
        w_cmd      = r_cmd;
        w_mem_req  = r_mem_req;
        w_if_rdata = r_if_rdata;
        w_d_rdata  = r_d_rdata;
        w_if_ready = 1'b0;
        w_d_ready  = 1'b0;
        w_err      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state   = ST_BUSY_D;
                    w_mem_req = 1'b1;
                    w_tmo     = '0;
                    w_cmd     = '{wr: d_wr, addr: d_addr, wdata: d_wdata};
                    w_run     = if_req ? (r_run + RUN_W'(1)) : '0;
                end else if (if_req) begin
                    w_state   = ST_BUSY_IF;
                    w_mem_req = 1'b1;
                    w_tmo     = '0;
                    w_cmd     = '{wr: 1'b0, addr: if_addr, wdata: 32'd0};
                    w_run     = '0;
                end
            end

            ST_BUSY_IF, ST_BUSY_D: begin
                if (mem_ack || w_timeout) begin
                    w_state   = ST_RESP;
                    w_mem_req = 1'b0;
                    w_cmd.wr  = 1'b0;
                    w_err     = !mem_ack;
                    if (r_state == ST_BUSY_D) begin
                        w_d_ready = 1'b1;
                        w_d_rdata = mem_ack ? w_read_data : 32'd0;
                    end else begin
                        w_if_ready = 1'b1;
                        w_if_rdata = mem_ack ? mem_rdata : 32'd0;
                    end
                end else begin
                    w_tmo = r_tmo + TMO_W'(1);
                end
            end

            ST_RESP: w_state = ST_IDLE;

            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_run      <= '0;
            r_tmo      <= '0;
            r_cmd      <= '0;
            r_mem_req  <= 1'b0;
            r_if_rdata <= 32'd0;
            r_d_rdata  <= 32'd0;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_run      <= w_run;
            r_tmo      <= w_tmo;
            r_cmd      <= w_cmd;
            r_mem_req  <= w_mem_req;
            r_if_rdata <= w_if_rdata;
            r_d_rdata  <= w_d_rdata;
            r_if_ready <= w_if_ready;
            r_d_ready  <= w_d_ready;
            r_err      <= w_err;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_wr    = r_cmd.wr;
    assign mem_addr  = r_cmd.addr;
    assign mem_wdata = r_cmd.wdata;
    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign d_rdata   = r_d_rdata;
    assign d_ready   = r_d_ready;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

    localparam int unsigned MAXR = 4;
    localparam int unsigned TMO  = 255;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        if_req    = 1'b0;
    logic [31:0] if_addr   = 32'd0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req     = 1'b0;
    logic        d_wr      = 1'b0;
    logic [31:0] d_addr    = 32'd0;
    logic [31:0] d_wdata   = 32'd0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack   = 1'b0;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Memory responder controls: ack_lat=0 never acks; stray injects one ack.
    int ack_lat = 1;
    int mem_age = 0;
    bit stray   = 1'b0;

    // Reference model: current job (0 none, 1 fetch, 2 data), its age, response cycle flag.
    int          m_job  = 0;
    bit          m_wr   = 1'b0;
    bit          m_resp = 1'b0;
    int          m_age  = 0;
    int          m_run  = 0;
    logic        e_req = 1'b0, e_wr = 1'b0, e_if_ready = 1'b0, e_d_ready = 1'b0, e_err = 1'b0;
    logic [31:0] e_addr = 32'd0, e_wdata = 32'd0, e_if_rdata = 32'd0, e_d_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_D_RUN(MAXR), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge from the inputs the DUT also samples there.
    task automatic model_step();
        if (rst) begin
            m_job = 0; m_resp = 1'b0; m_age = 0; m_run = 0; m_wr = 1'b0;
            e_req = 1'b0; e_wr = 1'b0; e_if_ready = 1'b0; e_d_ready = 1'b0; e_err = 1'b0;
            e_addr = 32'd0; e_wdata = 32'd0; e_if_rdata = 32'd0; e_d_rdata = 32'd0;
        end else begin
            e_if_ready = 1'b0; e_d_ready = 1'b0; e_err = 1'b0;
            if (m_resp) begin
                m_resp = 1'b0;
            end else if (m_job != 0) begin
                m_age++;
                if (mem_ack || m_age >= int'(TMO)) begin
                    if (m_job == 1) begin
                        e_if_ready = 1'b1;
                        e_if_rdata = mem_ack ? mem_rdata : 32'd0;
                    end else begin
                        e_d_ready = 1'b1;
                        e_d_rdata = (mem_ack && !m_wr) ? mem_rdata : 32'd0;
                    end
                    e_err = !mem_ack; e_req = 1'b0; e_wr = 1'b0; m_job = 0; m_resp = 1'b1;
                end
            end else if (d_req && !(if_req && m_run >= int'(MAXR))) begin
                m_job = 2; m_wr = d_wr; m_age = 0;
                e_req = 1'b1; e_wr = d_wr; e_addr = d_addr; e_wdata = d_wdata;
                m_run = if_req ? ((m_run < int'(MAXR)) ? m_run + 1 : int'(MAXR)) : 0;
            end else if (if_req) begin
                m_job = 1; m_wr = 1'b0; m_age = 0; m_run = 0;
                e_req = 1'b1; e_wr = 1'b0; e_addr = if_addr;
            end
        end
    endtask

    // One clock: model at the rising edge, compare and memory response at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
        chk("if_ready", {31'd0, if_ready}, {31'd0, e_if_ready});
        chk("d_ready", {31'd0, d_ready}, {31'd0, e_d_ready});
        chk("err", {31'd0, err}, {31'd0, e_err});
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        if (e_req) begin
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wr", {31'd0, mem_wr}, {31'd0, e_wr});
            if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);
        end
        if (mem_req) mem_age++; else mem_age = 0;
        if ((ack_lat > 0 && mem_req && mem_age == ack_lat + 1) || stray) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_val(mem_addr);
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
        end
    endtask

    task automatic wait_rdy(input bit is_d, input int lim, output int n, output int nreq);
        logic rdy;
        n = 0; nreq = 0;
        do begin
            tick();
            n++;
            if (mem_req) nreq++;
            rdy = is_d ? d_ready : if_ready;
        end while (!rdy && n < lim);
        chk(is_d ? "d_ready_seen" : "if_ready_seen", {31'd0, rdy}, 32'd1);
    endtask

    initial begin
        int          n, nreq, bad, ng, pulses;
        bit          prev;
        logic [31:0] got     [6];
        logic [31:0] exp_ord [6];

        exp_ord = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h4000, 32'h210};
        foreach (got[i]) got[i] = 32'd0;

        // Reset with both requests pending: nothing may be granted.
        if_req = 1'b1; d_req = 1'b1; if_addr = 32'h4000; d_addr = 32'h200;
        tick();
        tick();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        if_req = 1'b0; d_req = 1'b0; rst = 1'b0;
        tick();

        // Lone load with 1-cycle ack latency.
        ack_lat = 1; d_addr = 32'h100; d_wr = 1'b0; d_req = 1'b1;
        wait_rdy(1'b1, 50, n, nreq);
        chk("ld_latency", 32'(n), 32'd3);
        chk("ld_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        tick();
        chk("ld_ready_pulse", {31'd0, d_ready}, 32'd0);
        chk("ld_rdata_hold", d_rdata, 32'hDEAD_BEEF);

        // Store with 3-cycle ack latency; bus must stay stable the whole access.
        ack_lat = 3; d_addr = 32'h180; d_wr = 1'b1; d_wdata = 32'h1234_5678; d_req = 1'b1;
        n = 0; nreq = 0; bad = 0;
        do begin
            tick();
            n++;
            if (mem_req) begin
                nreq++;
                if (mem_wr !== 1'b1 || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h180) bad++;
            end
        end while (!d_ready && n < 50);
        chk("st_ready_seen", {31'd0, d_ready}, 32'd1);
        chk("st_latency", 32'(n), 32'd5);
        chk("st_req_cycles", 32'(nreq), 32'd4);
        chk("st_bus_stable", 32'(bad), 32'd0);
        chk("st_rdata", d_rdata, 32'd0);
        d_req = 1'b0; d_wr = 1'b0; pulses = 0;
        repeat (4) begin
            tick();
            if (d_ready) pulses++;
        end
        chk("st_single_pulse", 32'(pulses), 32'd0);

        // Both ports requesting continuously: D,D,D,D,IF,D.
        ack_lat = 1; if_addr = 32'h4000; if_req = 1'b1; d_addr = 32'h200; d_req = 1'b1;
        ng = 0; n = 0; prev = 1'b0;
        while (ng < 6 && n < 200) begin
            tick();
            n++;
            if (mem_req && !prev) begin
                got[ng] = mem_addr;
                ng++;
            end
            prev = mem_req;
            if (d_ready) d_addr = d_addr + 32'd4;
        end
        for (int i = 0; i < 6; i++) chk($sformatf("order%0d", i), got[i], exp_ord[i]);
        n = 0;
        while ((if_req || d_req) && n < 100) begin
            tick();
            n++;
            if (d_ready) d_req = 1'b0;
            if (if_ready) if_req = 1'b0;
        end
        chk("drain_done", {30'd0, if_req, d_req}, 32'd0);
        tick();
        chk("fetch_rdata", if_rdata, 32'hC0DE_4000);

        // Fetch never acknowledged: abort after TIMEOUT busy cycles.
        ack_lat = 0; if_addr = 32'h4400; if_req = 1'b1;
        wait_rdy(1'b0, 400, n, nreq);
        chk("to_req_cycles", 32'(nreq), 32'd255);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_if_rdata", if_rdata, 32'd0);
        chk("to_d_ready", {31'd0, d_ready}, 32'd0);
        if_req = 1'b0;
        tick();
        chk("to_err_pulse", {31'd0, err}, 32'd0);

        // Reset in the middle of a data access, then a stray ack.
        ack_lat = 10; d_addr = 32'h300; d_wr = 1'b0; d_req = 1'b1;
        repeat (3) tick();
        chk("rb_busy", {31'd0, mem_req}, 32'd1);
        rst = 1'b1; d_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("rb_req_drop", {31'd0, mem_req}, 32'd0);
        chk("rb_no_ready", {31'd0, d_ready}, 32'd0);
        stray = 1'b1;
        tick();
        stray = 1'b0;
        pulses = 0;
        repeat (5) begin
            tick();
            if (d_ready || mem_req || err) pulses++;
        end
        chk("rb_quiet", 32'(pulses), 32'd0);
        ack_lat = 1; d_addr = 32'h100; d_req = 1'b1;
        wait_rdy(1'b1, 50, n, nreq);
        chk("rb_next_latency", 32'(n), 32'd3);
        chk("rb_next_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
